// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle add/subtract, CHUNK bits per clock.
// LSB chunk first, one carry flop between chunks, start/done handshake.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  input  logic             carry_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  int               base;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] res_next;
  logic             cmsb;
  logic             last;

  // Next-state: chunk adder, operand load on accept, flag capture on last chunk
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    base     = int'(cnt_q) * CHUNK;
    last     = (cnt_q == CW'(N - 1));
    csum     = {1'b0, a_q[base +: CHUNK]}
             + {1'b0, b_q[base +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_q};
    res_next = res_q;
    res_next[base +: CHUNK] = csum[CHUNK-1:0];
    // Only meaningful on the last chunk, where the top result bit is WIDTH-1.
    cmsb     = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ csum[CHUNK-1];

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          res_d   = '0;
          a_d     = value1;
          b_d     = mode ? ~value2 : value2;
          carry_d = mode ? ~carry_in : carry_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d   = res_next;
        carry_d = csum[CHUNK];
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          sum_d   = res_next;
          cout_d  = csum[CHUNK];
          ovf_d   = cmsb ^ csum[CHUNK];
          zero_d  = (res_next == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run and clears outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign ready     = (state_q != S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: directed checks over four width/chunk configs.
// Hand-computed expectations, immediate assertions at each check point.
module tb_chunked_serial_adder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  logic fin = 1'b0;

  always #5 clock = ~clock;

  logic       s0 = 0, m0 = 0, c0 = 0;
  logic [7:0] a0 = 0, b0 = 0, r0;
  logic       rdy0, bsy0, dn0, co0, ov0, z0;
  logic       s1 = 0, m1 = 0, c1 = 0;
  logic [7:0] a1 = 0, b1 = 0, r1;
  logic       rdy1, bsy1, dn1, co1, ov1, z1;
  logic        s2 = 0, m2 = 0, c2 = 0;
  logic [31:0] a2 = 0, b2 = 0, r2;
  logic        rdy2, bsy2, dn2, co2, ov2, z2;
  logic        s3 = 0, m3 = 0, c3 = 0;
  logic [15:0] a3 = 0, b3 = 0, r3;
  logic        rdy3, bsy3, dn3, co3, ov3, z3;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) u0 (
    .clock(clock), .reset(reset), .start(s0), .mode(m0),
    .value1(a0), .value2(b0), .carry_in(c0),
    .ready(rdy0), .busy(bsy0), .done(dn0), .sum(r0),
    .carry_out(co0), .overflow(ov0), .zero(z0));

  chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) u1 (
    .clock(clock), .reset(reset), .start(s1), .mode(m1),
    .value1(a1), .value2(b1), .carry_in(c1),
    .ready(rdy1), .busy(bsy1), .done(dn1), .sum(r1),
    .carry_out(co1), .overflow(ov1), .zero(z1));

  chunked_serial_adder u2 (
    .clock(clock), .reset(reset), .start(s2), .mode(m2),
    .value1(a2), .value2(b2), .carry_in(c2),
    .ready(rdy2), .busy(bsy2), .done(dn2), .sum(r2),
    .carry_out(co2), .overflow(ov2), .zero(z2));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u3 (
    .clock(clock), .reset(reset), .start(s3), .mode(m3),
    .value1(a3), .value2(b3), .carry_in(c3),
    .ready(rdy3), .busy(bsy3), .done(dn3), .sum(r3),
    .carry_out(co3), .overflow(ov3), .zero(z3));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    if (!fin) begin
      n_fail++;
      $error("FAIL timeout: test did not finish");
      $finish;
    end
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", rdy2, 1'b1);
    chk("rst_busy", bsy2, 1'b0);
    chk("rst_done", dn2, 1'b0);
    chk("rst_sum", r2, 32'h0);
    chk("rst_flags", {co2, ov2, z2}, 3'b000);
    chk("rst_ready_u3", rdy3, 1'b1);

    a0 = 8'hFF; b0 = 8'h01; c0 = 0; m0 = 0; s0 = 1;
    tick();
    s0 = 0;
    chk("t1_busy", bsy0, 1'b1);
    chk("t1_ready", rdy0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_nodone", dn0, 1'b0);
    end
    tick();
    chk("t1_done", dn0, 1'b1);
    chk("t1_sum", r0, 8'h00);
    chk("t1_flags", {co0, ov0, z0}, 3'b101);
    tick();
    chk("t1_pulse", dn0, 1'b0);
    chk("t1_idle", {rdy0, bsy0}, 2'b10);
    chk("t1_hold", {r0, z0}, {8'h00, 1'b1});

    a0 = 8'h7F; b0 = 8'h01; s0 = 1;
    tick();
    s0 = 0;
    repeat (4) tick();
    chk("t2_done", dn0, 1'b1);
    chk("t2_sum", r0, 8'h80);
    chk("t2_flags", {co0, ov0, z0}, 3'b010);

    a1 = 8'h05; b1 = 8'h07; c1 = 0; m1 = 1; s1 = 1;
    tick();
    s1 = 0;
    tick();
    chk("t3_nodone", dn1, 1'b0);
    tick();
    chk("t3_done", dn1, 1'b1);
    chk("t3_sum", r1, 8'hFE);
    chk("t3_flags", {co1, ov1, z1}, 3'b000);

    a1 = 8'h10; b1 = 8'h01; c1 = 1; s1 = 1;
    tick();
    s1 = 0;
    repeat (2) tick();
    chk("t4_done", dn1, 1'b1);
    chk("t4_sum", r1, 8'h0E);
    chk("t4_flags", {co1, ov1, z1}, 3'b100);

    a2 = 32'h12345678; b2 = 32'h11111111; c2 = 0; m2 = 0; s2 = 1;
    tick();
    s2 = 0;
    repeat (2) tick();
    a2 = 32'hFFFFFFFF; b2 = 32'h00000001; s2 = 1; m2 = 1;
    repeat (3) tick();
    chk("t5_busy", bsy2, 1'b1);
    s2 = 0;
    repeat (2) tick();
    chk("t5_nodone", dn2, 1'b0);
    chk("t5_nopartial", r2, 32'h0);
    tick();
    chk("t5_done", dn2, 1'b1);
    chk("t5_sum", r2, 32'h23456789);
    chk("t5_flags", {co2, ov2, z2}, 3'b000);

    a2 = 32'hFFFFFFFF; b2 = 32'h0; c2 = 1; m2 = 0; s2 = 1;
    tick();
    s2 = 0;
    chk("t6_busy", {rdy2, bsy2, dn2}, 3'b010);
    chk("t6_hold", r2, 32'h23456789);
    repeat (7) tick();
    chk("t6_nodone", dn2, 1'b0);
    chk("t6_nopartial", r2, 32'h23456789);
    tick();
    chk("t6_done", dn2, 1'b1);
    chk("t6_sum", r2, 32'h0);
    chk("t6_flags", {co2, ov2, z2}, 3'b101);

    a2 = 32'hFFFFFFFF; b2 = 32'h1; c2 = 1; s2 = 1;
    tick();
    s2 = 0;
    repeat (4) tick();
    chk("t7_busy", bsy2, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t7_state", {rdy2, bsy2, dn2}, 3'b100);
    chk("t7_sum", r2, 32'h0);
    chk("t7_flags", {co2, ov2, z2}, 3'b000);
    #2 reset = 1'b0;
    a2 = 32'd3; b2 = 32'd4; c2 = 0; m2 = 0; s2 = 1;
    tick();
    s2 = 0;
    repeat (7) tick();
    chk("t7_nodone", dn2, 1'b0);
    tick();
    chk("t7_done", dn2, 1'b1);
    chk("t7_res", r2, 32'd7);
    chk("t7_rflags", {co2, ov2, z2}, 3'b000);

    a3 = 16'h8000; b3 = 16'h8000; c3 = 0; m3 = 0; s3 = 1;
    tick();
    s3 = 0;
    chk("t8_nodone", {bsy3, dn3}, 2'b10);
    tick();
    chk("t8_done", dn3, 1'b1);
    chk("t8_sum", r3, 16'h0);
    chk("t8_flags", {co3, ov3, z3}, 3'b111);

    fin = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
